// File: rtl/board_pkg.sv
// Shared definitions for the board state manager: piece codes, FSM states,
// the one-deep undo record and the reset layout.
package board_pkg;

  // Record field widths cover the largest legal board (8x8) and 4-bit piece codes.
  localparam int unsigned POS_MAX_W  = 6;
  localparam int unsigned CODE_MAX_W = 4;

  localparam logic [3:0] PC_EMPTY  = 4'd0;
  localparam logic [3:0] PC_PAWN   = 4'd1;
  localparam logic [3:0] PC_KNIGHT = 4'd2;
  localparam logic [3:0] PC_BISHOP = 4'd3;
  localparam logic [3:0] PC_ROOK   = 4'd4;
  localparam logic [3:0] PC_QUEEN  = 4'd5;
  localparam logic [3:0] PC_KING   = 4'd6;
  // Black pieces use the white code plus this offset.
  localparam logic [3:0] PC_BLACK_OFS = 4'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  typedef struct packed {
    logic [POS_MAX_W-1:0]  from_pos;
    logic [POS_MAX_W-1:0]  to_pos;
    logic [CODE_MAX_W-1:0] piece;
    logic [CODE_MAX_W-1:0] captured;
  } undo_rec_t;

  // White back-rank piece for a given column.
  function automatic logic [3:0] back_rank(input int unsigned col);
    case (col)
      0, 7:    return PC_ROOK;
      1, 6:    return PC_KNIGHT;
      2, 5:    return PC_BISHOP;
      3:       return PC_QUEEN;
      4:       return PC_KING;
      default: return PC_EMPTY;
    endcase
  endfunction

  // Reset contents of square (row, col): standard chess on 8x8, empty otherwise.
  function automatic logic [3:0] init_code(input int unsigned dim,
                                           input int unsigned row,
                                           input int unsigned col);
    if (dim != 8) return PC_EMPTY;
    case (row)
      0:       return back_rank(col) + PC_BLACK_OFS;
      1:       return PC_PAWN + PC_BLACK_OFS;
      6:       return PC_PAWN;
      7:       return back_rank(col);
      default: return PC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/board_undo_reg.sv
// One-deep undo record for the last committed move.
//   i_wr    : store i_rec and mark the record valid (a commit)
//   i_clr   : invalidate the record (an undo was performed)
//   o_rec   : stored record, o_valid : record may be replayed
module board_undo_reg
  import board_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_wr,
  input  logic      i_clr,
  input  undo_rec_t i_rec,
  output undo_rec_t o_rec,
  output logic      o_valid
);

  undo_rec_t r_rec;
  logic      r_valid;

  // A commit always overwrites the previous record.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rec   <= '0;
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_rec   <= i_rec;
      r_valid <= 1'b1;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rec   = r_rec;
  assign o_valid = r_valid;

endmodule

// File: rtl/board_state_mgr.sv
// Board state manager: holds the board, lets the user lift a piece, drop it on
// a legal square (or back on its origin to cancel), and undo one committed move.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   figure_xy           display query square {row, col}
//   figure_position     mouse square {row, col}
//   pick_piece          lift the piece at figure_position
//   place_piece         drop the held piece at figure_position
//   undo_req            revert the last committed move
//   possible_moves      legal-target mask, (r,c) -> bit DIM*DIM-1-(r*DIM+c)
//   board               current contents, board[row][col]
//   figure_code         registered display code for figure_xy
//   figure_taken        held piece code, pp_pos its origin square
//   holding             piece is held
//   move_done, illegal_move, undo_done  single-cycle pulses
//   captured_code       target contents at the last commit
module board_state_mgr
  import board_pkg::*;
#(
  parameter int unsigned        DIM       = 8,
  parameter int unsigned        CODE_W    = 4,
  parameter logic [CODE_W-1:0]  MARK_CODE = 4'hD
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2*$clog2(DIM)-1:0]              figure_xy,
  input  logic [2*$clog2(DIM)-1:0]              figure_position,
  input  logic                                  pick_piece,
  input  logic                                  place_piece,
  input  logic                                  undo_req,
  input  logic [DIM*DIM-1:0]                    possible_moves,
  output logic [DIM-1:0][DIM-1:0][CODE_W-1:0]   board,
  output logic [CODE_W-1:0]                     figure_code,
  output logic [CODE_W-1:0]                     figure_taken,
  output logic [2*$clog2(DIM)-1:0]              pp_pos,
  output logic                                  holding,
  output logic                                  move_done,
  output logic                                  illegal_move,
  output logic                                  undo_done,
  output logic [CODE_W-1:0]                     captured_code
);

  localparam int unsigned AW    = $clog2(DIM);
  localparam int unsigned POS_W = 2 * AW;

  state_t                               r_state, w_state_nxt;
  logic [DIM-1:0][DIM-1:0][CODE_W-1:0]  r_board, w_init;
  logic [DIM-1:0][DIM-1:0]              w_mask_rc;
  logic [CODE_W-1:0]                    r_fig_code, r_taken, r_captured;
  logic [POS_W-1:0]                     r_pp_pos;
  logic                                 r_move_done, r_illegal, r_undo_done;

  logic                                 w_pick, w_cancel, w_commit, w_illegal, w_undo;
  logic                                 w_undo_valid;
  undo_rec_t                            w_rec_in, w_rec_q;

  // Square decode for the mouse, the display query, the origin and the undo record.
  logic [AW-1:0] w_sel_row, w_sel_col, w_xy_row, w_xy_col, w_pp_row, w_pp_col;
  logic [AW-1:0] w_ufr_row, w_ufr_col, w_uto_row, w_uto_col;
  logic [POS_W-1:0] w_ufr_pos, w_uto_pos;
  logic [CODE_W-1:0] w_sel_code, w_xy_code;

  assign w_sel_row  = figure_position[POS_W-1:AW];
  assign w_sel_col  = figure_position[AW-1:0];
  assign w_xy_row   = figure_xy[POS_W-1:AW];
  assign w_xy_col   = figure_xy[AW-1:0];
  assign w_pp_row   = r_pp_pos[POS_W-1:AW];
  assign w_pp_col   = r_pp_pos[AW-1:0];
  assign w_ufr_pos  = POS_W'(w_rec_q.from_pos);
  assign w_uto_pos  = POS_W'(w_rec_q.to_pos);
  assign w_ufr_row  = w_ufr_pos[POS_W-1:AW];
  assign w_ufr_col  = w_ufr_pos[AW-1:0];
  assign w_uto_row  = w_uto_pos[POS_W-1:AW];
  assign w_uto_col  = w_uto_pos[AW-1:0];
  assign w_sel_code = r_board[w_sel_row][w_sel_col];
  assign w_xy_code  = r_board[w_xy_row][w_xy_col];

  // Mask bits are stored MSB-first (square 0,0 is the top bit); remap to [row][col].
  for (genvar gr = 0; gr < DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < DIM; gc++) begin : g_col
      assign w_mask_rc[gr][gc] = possible_moves[DIM*DIM-1-(gr*DIM+gc)];
      assign w_init[gr][gc]    = CODE_W'(init_code(DIM, gr, gc));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; pick beats undo, HELD only honours place.
  always_comb begin
    w_state_nxt = r_state;
    w_pick      = 1'b0;
    w_cancel    = 1'b0;
    w_commit    = 1'b0;
    w_illegal   = 1'b0;
    w_undo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pick_piece) begin
          if (w_sel_code != '0) begin
            w_pick      = 1'b1;
            w_state_nxt = ST_HELD;
          end
        end else if (undo_req && w_undo_valid) begin
          w_undo = 1'b1;
        end
      end
      ST_HELD: begin
        if (place_piece) begin
          if (figure_position == r_pp_pos) begin
            w_cancel    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_mask_rc[w_sel_row][w_sel_col]) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Board and output registers; every read uses pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_board     <= w_init;
      r_fig_code  <= '0;
      r_taken     <= '0;
      r_pp_pos    <= '0;
      r_captured  <= '0;
      r_move_done <= 1'b0;
      r_illegal   <= 1'b0;
      r_undo_done <= 1'b0;
    end else begin
      r_move_done <= w_commit;
      r_illegal   <= w_illegal;
      r_undo_done <= w_undo;
      // Highlight empty legal targets only while a piece is in hand.
      if ((r_state == ST_HELD) && (w_xy_code == '0) && w_mask_rc[w_xy_row][w_xy_col])
        r_fig_code <= MARK_CODE;
      else
        r_fig_code <= w_xy_code;
      if (w_pick) begin
        r_board[w_sel_row][w_sel_col] <= '0;
        r_taken                       <= w_sel_code;
        r_pp_pos                      <= figure_position;
      end
      if (w_cancel) r_board[w_pp_row][w_pp_col] <= r_taken;
      if (w_commit) begin
        r_board[w_sel_row][w_sel_col] <= r_taken;
        r_captured                    <= w_sel_code;
      end
      if (w_undo) begin
        r_board[w_ufr_row][w_ufr_col] <= CODE_W'(w_rec_q.piece);
        r_board[w_uto_row][w_uto_col] <= CODE_W'(w_rec_q.captured);
      end
    end
  end

  always_comb begin
    w_rec_in          = '0;
    w_rec_in.from_pos = POS_MAX_W'(r_pp_pos);
    w_rec_in.to_pos   = POS_MAX_W'(figure_position);
    w_rec_in.piece    = CODE_MAX_W'(r_taken);
    w_rec_in.captured = CODE_MAX_W'(w_sel_code);
  end

  board_undo_reg u_undo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_commit),
    .i_clr   (w_undo),
    .i_rec   (w_rec_in),
    .o_rec   (w_rec_q),
    .o_valid (w_undo_valid)
  );

  assign board         = r_board;
  assign figure_code   = r_fig_code;
  assign figure_taken  = r_taken;
  assign pp_pos        = r_pp_pos;
  assign holding       = (r_state == ST_HELD);
  assign move_done     = r_move_done;
  assign illegal_move  = r_illegal;
  assign undo_done     = r_undo_done;
  assign captured_code = r_captured;

endmodule
